// File: rtl/spi_con_multi.sv
`timescale 1ns/1ps
// SPI master: one full-duplex word per trigger, run-time CPOL/CPHA, per-chip CS, CS-held bursts.
// Latency: trigger sampled in cycle T -> data_valid_out high in cycle T + 3 + 2*DATA_WIDTH*HALF.
// Backpressure: none; trigger_in is ignored while busy_out=1 (START/TRANSMIT/COMPLETE).
//
// Ports:
//   clk_in, rst_n_in                 clock, async active-low reset
//   data_in, trigger_in              word to send and start strobe (accepted in IDLE or HOLD)
//   mode_in[1]=CPOL, mode_in[0]=CPHA latched only when a word is accepted from IDLE
//   chip_idx_in                      target chip, latched only from IDLE (out of range: no CS asserts)
//   hold_cs_in, cs_release_in        keep CS low after the word / end a held burst
//   busy_out, data_out, data_valid_out
//   chip_data_out (COPI), chip_data_in (CIPO), chip_clk_out (SCLK), chip_sel_out (active-low CS)
// Optional build macro SPI_LSB_FIRST_EN adds lsb_first_in (latched from IDLE, reused through HOLD).

module spi_con_multi #(
    parameter int DATA_WIDTH      = 8,
    parameter int DATA_CLK_PERIOD = 100,
    parameter int NUM_CHIPS       = 4,
    localparam int IDX_W = (NUM_CHIPS > 1) ? $clog2(NUM_CHIPS) : 1
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  trigger_in,
    input  logic [1:0]            mode_in,
    input  logic [IDX_W-1:0]      chip_idx_in,
    input  logic                  hold_cs_in,
    input  logic                  cs_release_in,
`ifdef SPI_LSB_FIRST_EN
    input  logic                  lsb_first_in,
`endif
    output logic                  busy_out,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid_out,
    output logic                  chip_data_out,
    input  logic                  chip_data_in,
    output logic                  chip_clk_out,
    output logic [NUM_CHIPS-1:0]  chip_sel_out
);

    localparam int HALF  = DATA_CLK_PERIOD / 2;
    localparam int HC_W  = (HALF > 1) ? $clog2(HALF) : 1;
    localparam int EC_W  = $clog2(2 * DATA_WIDTH + 1);
    localparam logic [HC_W-1:0] HALF_LAST = HC_W'(HALF - 1);
    localparam logic [EC_W-1:0] EDGE_LAST = EC_W'(2 * DATA_WIDTH);

    typedef enum logic [2:0] {IDLE, START, TRANSMIT, COMPLETE, HOLD} state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] tx_sr;
    logic [DATA_WIDTH-1:0] rx_sr;
    logic [HC_W-1:0]       half_cnt;
    logic [EC_W-1:0]       edge_cnt;
    logic [1:0]            mode_q;
    logic [IDX_W-1:0]      idx_q;
    logic                  hold_q;
    logic                  lsb_q;

    logic [EC_W-1:0]       edge_nxt;
    logic                  leading;
    logic                  tx_bit;
    logic [DATA_WIDTH-1:0] tx_shifted;
    logic [DATA_WIDTH-1:0] rx_shifted;

`ifndef SPI_LSB_FIRST_EN
    assign lsb_q = 1'b0;
`endif

    // Edge numbering starts at 1, so odd edge numbers move SCLK away from CPOL.
    assign edge_nxt   = edge_cnt + EC_W'(1);
    assign leading    = edge_nxt[0];
    assign tx_bit     = lsb_q ? tx_sr[0] : tx_sr[DATA_WIDTH-1];
    assign tx_shifted = lsb_q ? (tx_sr >> 1) : (tx_sr << 1);
    // LSB-first fills from the MSB side so the first sampled bit ends up in bit 0.
    assign rx_shifted = lsb_q ? {chip_data_in, rx_sr[DATA_WIDTH-1:1]}
                              : {rx_sr[DATA_WIDTH-2:0], chip_data_in};

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state          <= IDLE;
            tx_sr          <= '0;
            rx_sr          <= '0;
            half_cnt       <= '0;
            edge_cnt       <= '0;
            mode_q         <= '0;
            idx_q          <= '0;
            hold_q         <= 1'b0;
`ifdef SPI_LSB_FIRST_EN
            lsb_q          <= 1'b0;
`endif
            busy_out       <= 1'b0;
            data_out       <= '0;
            data_valid_out <= 1'b0;
            chip_data_out  <= 1'b0;
            chip_clk_out   <= 1'b0;
            chip_sel_out   <= '1;
        end else begin
            data_valid_out <= 1'b0;
            case (state)
                IDLE: begin
                    chip_sel_out <= '1;
                    chip_clk_out <= mode_q[1];
                    if (trigger_in) begin
                        tx_sr        <= data_in;
                        mode_q       <= mode_in;
                        idx_q        <= chip_idx_in;
                        hold_q       <= hold_cs_in;
`ifdef SPI_LSB_FIRST_EN
                        lsb_q        <= lsb_first_in;
`endif
                        // Move SCLK to the new idle level while CS is still high.
                        chip_clk_out <= mode_in[1];
                        busy_out     <= 1'b1;
                        state        <= START;
                    end
                end
                START: begin
                    for (int i = 0; i < NUM_CHIPS; i++) begin
                        if (idx_q == IDX_W'(i)) chip_sel_out[i] <= 1'b0;
                    end
                    half_cnt <= '0;
                    edge_cnt <= '0;
                    rx_sr    <= '0;
                    // CPHA=0 needs the first bit on the wire before the first leading edge.
                    if (!mode_q[0]) begin
                        chip_data_out <= tx_bit;
                        tx_sr         <= tx_shifted;
                    end
                    state <= TRANSMIT;
                end
                TRANSMIT: begin
                    if (half_cnt == HALF_LAST) begin
                        half_cnt     <= '0;
                        edge_cnt     <= edge_nxt;
                        chip_clk_out <= ~chip_clk_out;
                        // CPHA=0 samples on leading edges, CPHA=1 on trailing edges.
                        if (leading ^ mode_q[0]) begin
                            rx_sr <= rx_shifted;
                        end else if (edge_nxt != EDGE_LAST) begin
                            chip_data_out <= tx_bit;
                            tx_sr         <= tx_shifted;
                        end
                        if (edge_nxt == EDGE_LAST) state <= COMPLETE;
                    end else begin
                        half_cnt <= half_cnt + HC_W'(1);
                    end
                end
                COMPLETE: begin
                    data_out       <= rx_sr;
                    data_valid_out <= 1'b1;
                    busy_out       <= 1'b0;
                    if (hold_q) begin
                        state <= HOLD;
                    end else begin
                        chip_sel_out <= '1;
                        state        <= IDLE;
                    end
                end
                HOLD: begin
                    chip_clk_out <= mode_q[1];
                    // Release wins over a simultaneous trigger.
                    if (cs_release_in) begin
                        chip_sel_out <= '1;
                        state        <= IDLE;
                    end else if (trigger_in) begin
                        tx_sr    <= data_in;
                        hold_q   <= hold_cs_in;
                        busy_out <= 1'b1;
                        state    <= START;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_con_multi.sv
`timescale 1ns/1ps
// Bench for spi_con_multi: DATA_WIDTH=8, HALF=2, NUM_CHIPS=4, plus a NUM_CHIPS=5 copy
// driven with an out-of-range chip index. A behavioural SPI slave supplies CIPO and
// captures COPI; a scoreboard holds expected words and is drained on each valid pulse.

module tb_spi_con_multi;

    localparam int DW  = 8;
    localparam int PER = 4;
    localparam int NC  = 4;
    localparam int LAT = 3 + 2 * DW * (PER / 2);

    logic          clk_in = 1'b0;
    logic          rst_n_in = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic          trigger_in = 1'b0;
    logic [1:0]    mode_in = '0;
    logic [1:0]    chip_idx_in = '0;
    logic          hold_cs_in = 1'b0;
    logic          cs_release_in = 1'b0;
    logic          busy_out;
    logic [DW-1:0] data_out;
    logic          data_valid_out;
    logic          chip_data_out;
    logic          chip_data_in;
    logic          chip_clk_out;
    logic [NC-1:0] chip_sel_out;

    // Second instance: five chips, driven with index 5.
    logic          trig2 = 1'b0;
    logic [2:0]    idx2 = '0;
    logic          busy2;
    logic [DW-1:0] data2;
    logic          valid2;
    logic          copi2;
    logic          sclk2;
    logic [4:0]    cs2;

    spi_con_multi #(.DATA_WIDTH(DW), .DATA_CLK_PERIOD(PER), .NUM_CHIPS(NC)) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .data_in(data_in), .trigger_in(trigger_in),
        .mode_in(mode_in), .chip_idx_in(chip_idx_in), .hold_cs_in(hold_cs_in),
        .cs_release_in(cs_release_in), .busy_out(busy_out), .data_out(data_out),
        .data_valid_out(data_valid_out), .chip_data_out(chip_data_out),
        .chip_data_in(chip_data_in), .chip_clk_out(chip_clk_out), .chip_sel_out(chip_sel_out)
    );

    spi_con_multi #(.DATA_WIDTH(DW), .DATA_CLK_PERIOD(PER), .NUM_CHIPS(5)) dut2 (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .data_in(8'h5A), .trigger_in(trig2),
        .mode_in(2'b00), .chip_idx_in(idx2), .hold_cs_in(1'b0),
        .cs_release_in(1'b0), .busy_out(busy2), .data_out(data2),
        .data_valid_out(valid2), .chip_data_out(copi2),
        .chip_data_in(1'b1), .chip_clk_out(sclk2), .chip_sel_out(cs2)
    );

    always #5 clk_in = ~clk_in;

    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // ---------------- behavioural slave ----------------
    logic [7:0] sl_tx = '0;
    logic [7:0] sl_rx = '0;
    logic [1:0] sl_mode = '0;
    logic       sl_first = 1'b0;
    int         sl_edges = 0;
    int         seen_seq = 0;
    logic [7:0] nxt_tx = '0;
    logic [1:0] nxt_mode = '0;
    int         load_seq = 0;
    logic       sl_lead;

    assign chip_data_in = sl_tx[7];

    always @(chip_clk_out or load_seq) begin
        if (load_seq != seen_seq) begin
            seen_seq = load_seq;
            sl_tx    = nxt_tx;
            sl_mode  = nxt_mode;
            sl_rx    = '0;
            sl_edges = 0;
            sl_first = 1'b1;
        end else if (rst_n_in && chip_sel_out != '1) begin
            sl_edges++;
            sl_lead = (chip_clk_out != sl_mode[1]);
            if (sl_lead != sl_mode[0]) begin
                sl_rx = {sl_rx[6:0], chip_data_out};
            end else if (sl_mode[0]) begin
                // CPHA=1: bit 7 is already on the wire for the first leading edge.
                if (!sl_first) sl_tx = sl_tx << 1;
                sl_first = 1'b0;
            end else begin
                sl_tx = sl_tx << 1;
            end
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [7:0] rx;
        logic [7:0] tx;
        logic       cpol;
        int         t0;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_valid = 0;

    always @(negedge clk_in) begin
        if (data_valid_out) begin
            n_valid++;
            check("valid_expected", 32'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                check("data_out", 32'(data_out), 32'(mon_e.rx));
                check("copi_word", 32'(sl_rx), 32'(mon_e.tx));
                check("sclk_edges", sl_edges, 2 * DW);
                check("sclk_end", 32'(chip_clk_out), 32'(mon_e.cpol));
                check("latency", cyc - mon_e.t0, LAT);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    // eff_mode is the mode the DUT should actually use (differs from m when reused in HOLD).
    task automatic send(input logic [7:0] d, input logic [1:0] m, input logic [1:0] idx,
                        input logic h, input logic [7:0] cipo, input logic [1:0] eff_mode);
        exp_t e;
        nxt_tx      = cipo;
        nxt_mode    = eff_mode;
        load_seq++;
        data_in     = d;
        mode_in     = m;
        chip_idx_in = idx;
        hold_cs_in  = h;
        trigger_in  = 1'b1;
        e.rx = cipo;
        e.tx = d;
        e.cpol = eff_mode[1];
        e.t0 = cyc;
        sb.push_back(e);
        tick(1);
        trigger_in = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int i;
        i = 0;
        while (sb.size() != 0 && i < 400) begin
            @(posedge clk_in);
            i++;
        end
        #1;
        check(tag, sb.size(), 0);
    endtask

    int   v0;
    int   k;
    logic busy_seen;
    logic cs2_high;
    int   n_valid2;
    logic [7:0] data2_cap;
    logic [7:0] cap2;
    logic sclk2_prev;

    initial begin
        // Reset values
        tick(3);
        check("rst_data_out", 32'(data_out), 0);
        check("rst_valid", 32'(data_valid_out), 0);
        check("rst_busy", 32'(busy_out), 0);
        check("rst_copi", 32'(chip_data_out), 0);
        check("rst_sclk", 32'(chip_clk_out), 0);
        check("rst_cs", 32'(chip_sel_out), 32'hF);
        rst_n_in = 1'b1;
        tick(2);

        // Mode 0, chip 2
        send(8'hA5, 2'd0, 2'd2, 1'b0, 8'h3C, 2'd0);
        tick(10);
        check("m0_cs_active", 32'(chip_sel_out), 32'b1011);
        check("m0_busy", 32'(busy_out), 1);
        wait_done("m0_done");
        tick(1);
        check("m0_cs_idle", 32'(chip_sel_out), 32'hF);
        check("m0_busy_idle", 32'(busy_out), 0);

        // Mode 3, chip 0
        send(8'h81, 2'd3, 2'd0, 1'b0, 8'hFF, 2'd3);
        tick(1);
        check("m3_sclk_idle_high", 32'(chip_clk_out), 1);
        tick(10);
        check("m3_cs_active", 32'(chip_sel_out), 32'b1110);
        wait_done("m3_done");
        tick(2);
        check("m3_sclk_after", 32'(chip_clk_out), 1);

        // Modes 1 and 2
        send(8'h5A, 2'd1, 2'd3, 1'b0, 8'h96, 2'd1);
        wait_done("m1_done");
        tick(2);
        send(8'hC3, 2'd2, 2'd0, 1'b0, 8'h69, 2'd2);
        wait_done("m2_done");
        tick(2);

        // Burst on chip 1: mode/idx of the second word must be ignored
        v0 = n_valid;
        send(8'h11, 2'd0, 2'd1, 1'b1, 8'hE7, 2'd0);
        wait_done("burst1_done");
        tick(2);
        check("hold_cs", 32'(chip_sel_out), 32'b1101);
        check("hold_busy", 32'(busy_out), 0);
        check("hold_sclk", 32'(chip_clk_out), 0);
        send(8'h22, 2'd3, 2'd3, 1'b0, 8'h4B, 2'd0);
        tick(10);
        check("burst2_cs", 32'(chip_sel_out), 32'b1101);
        wait_done("burst2_done");
        tick(1);
        check("burst_cs_end", 32'(chip_sel_out), 32'hF);
        check("burst_valids", n_valid - v0, 2);

        // HOLD: release and trigger together
        send(8'h33, 2'd0, 2'd0, 1'b1, 8'h0F, 2'd0);
        wait_done("hold2_done");
        tick(1);
        check("hold2_cs", 32'(chip_sel_out), 32'b1110);
        v0 = n_valid;
        data_in = 8'h44;
        cs_release_in = 1'b1;
        trigger_in = 1'b1;
        tick(1);
        cs_release_in = 1'b0;
        trigger_in = 1'b0;
        check("release_cs", 32'(chip_sel_out), 32'hF);
        busy_seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk_in);
            busy_seen |= busy_out;
        end
        tick(1);
        check("release_no_busy", 32'(busy_seen), 0);
        check("release_no_valid", n_valid - v0, 0);

        // Reset in the middle of a word
        send(8'hF0, 2'd0, 2'd2, 1'b0, 8'hAA, 2'd0);
        k = 0;
        while (sl_edges < 7 && k < 100) begin
            @(negedge clk_in);
            k++;
        end
        check("reach_edge7", 32'(sl_edges >= 7), 1);
        rst_n_in = 1'b0;
        #1;
        check("midrst_cs", 32'(chip_sel_out), 32'hF);
        check("midrst_sclk", 32'(chip_clk_out), 0);
        check("midrst_busy", 32'(busy_out), 0);
        check("midrst_data", 32'(data_out), 0);
        check("midrst_valid", 32'(data_valid_out), 0);
        sb.delete();
        v0 = n_valid;
        tick(2);
        rst_n_in = 1'b1;
        tick(50);
        check("midrst_no_valid", n_valid - v0, 0);
        send(8'h3C, 2'd0, 2'd1, 1'b0, 8'h5A, 2'd0);
        wait_done("post_rst_done");
        tick(2);

        // Trigger during TRANSMIT is ignored
        v0 = n_valid;
        send(8'h96, 2'd1, 2'd3, 1'b0, 8'hC3, 2'd1);
        tick(10);
        data_in = 8'hFF;
        mode_in = 2'd0;
        trigger_in = 1'b1;
        tick(1);
        trigger_in = 1'b0;
        wait_done("busy_trig_done");
        tick(40);
        check("busy_trig_one_valid", n_valid - v0, 1);

        // Out-of-range chip index on the five-chip instance
        idx2 = 3'd5;
        trig2 = 1'b1;
        tick(1);
        trig2 = 1'b0;
        cs2_high = 1'b1;
        n_valid2 = 0;
        data2_cap = '0;
        cap2 = '0;
        sclk2_prev = sclk2;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk_in);
            cs2_high &= (cs2 == 5'h1F);
            if (sclk2 && !sclk2_prev) cap2 = {cap2[6:0], copi2};
            sclk2_prev = sclk2;
            if (valid2) begin
                n_valid2++;
                data2_cap = data2;
            end
        end
        tick(1);
        check("oor_cs_high", 32'(cs2_high), 1);
        check("oor_valid_count", n_valid2, 1);
        check("oor_data", 32'(data2_cap), 32'hFF);
        check("oor_copi", 32'(cap2), 32'h5A);
        check("oor_busy_end", 32'(busy2), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_chk);
        $fatal(1);
    end

endmodule
